// File: rtl/exp_sched_pkg.sv
// Shared constants and types for the exp-scale LUT scheduler.
package exp_sched_pkg;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_IDX_W     = 4;
    localparam int DEF_SCALE_W   = 12;
    localparam int DEF_LUT_LAT   = 1;
    localparam int DEF_OUT_DEPTH = 4;
    localparam int DEF_ID_W      = $clog2(DEF_NUM_REQ);

    // One stage of the LUT-latency tracking pipeline.
    typedef struct packed {
        logic                vld;
        logic [DEF_ID_W-1:0] id;
    } tag_t;

    // One entry of the response FIFO.
    typedef struct packed {
        logic [DEF_ID_W-1:0]    id;
        logic [DEF_SCALE_W-1:0] scale;
    } rsp_t;

endpackage

// File: rtl/exp_scale_sched_rr_arbiter.sv
// Round-robin arbiter: searches from the pointer, grants one requester,
// and moves the pointer just past the winner.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx
);

    logic [ID_W-1:0] ptr;
    logic            found;

    // Pick the first asserted request at or after the pointer (with wrap).
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int cand;
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (en && !found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = ID_W'(cand);
            end
        end
    end

    // Pointer advances past the winner only when a grant is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end

endmodule

// File: rtl/exp_scale_sched.sv
// Shares one registered exp-scale LUT among several requesters: round-robin
// issue with credit limiting, tag pipeline matching the LUT latency, and a
// response FIFO that absorbs consumer backpressure.
module exp_scale_sched
    import exp_sched_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int IDX_W     = DEF_IDX_W,
    parameter int SCALE_W   = DEF_SCALE_W,
    parameter int LUT_LAT   = DEF_LUT_LAT,
    parameter int OUT_DEPTH = DEF_OUT_DEPTH,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*IDX_W-1:0] req_idx,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [IDX_W-1:0]         lut_idx,
    input  logic [SCALE_W-1:0]       lut_scale,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [SCALE_W-1:0]       rsp_scale,
    output logic                     busy
);

    localparam int ADDR_W = $clog2(OUT_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    tag_t             tag_pipe [LUT_LAT];
    rsp_t             fifo_mem [OUT_DEPTH];
    rsp_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] fifo_cnt;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             issue_ok;
    logic             grant;
    logic [ID_W-1:0]  gnt_idx;
    int               tag_cnt;

    assign fifo_cnt = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                      (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign push     = tag_pipe[LUT_LAT-1].vld;
    assign pop      = !empty && rsp_ready;
    assign grant    = |req_ready;

    // Credits count lookups in flight plus queued responses, both from
    // registered state, so a pop only frees its credit on the next cycle.
    always_comb begin
        tag_cnt = 0;
        for (int k = 0; k < LUT_LAT; k++) begin
            if (tag_pipe[k].vld) tag_cnt = tag_cnt + 1;
        end
        issue_ok = (int'(fifo_cnt) + tag_cnt) < OUT_DEPTH;
        busy     = (tag_cnt != 0) || !empty;
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .en      (issue_ok && !rst),
        .gnt     (req_ready),
        .gnt_idx (gnt_idx)
    );

    // Drive the winner's index to the LUT; idle index is zero.
    always_comb begin
        lut_idx = '0;
        if (grant) lut_idx = req_idx[int'(gnt_idx)*IDX_W +: IDX_W];
    end

    // Tag pipeline tracks which requester owns each LUT result.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LUT_LAT; k++) tag_pipe[k] <= '0;
        end else begin
            tag_pipe[0] <= tag_t'{vld: grant, id: gnt_idx};
            for (int k = 1; k < LUT_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
        end
    end

    // FIFO storage; contents need no reset because the head is masked when empty.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_mem[wr_ptr[ADDR_W-1:0]] <= rsp_t'{id: tag_pipe[LUT_LAT-1].id, scale: lut_scale};
        end
    end

    // FIFO pointers with an extra wrap bit for full/empty disambiguation.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Credit accounting must make a write into a full FIFO impossible.
    always_ff @(posedge clk) begin
        if (!rst && push) assert (!full);
    end

    assign head      = fifo_mem[rd_ptr[ADDR_W-1:0]];
    assign rsp_valid = !empty;
    assign rsp_id    = empty ? '0 : head.id;
    assign rsp_scale = empty ? '0 : head.scale;

endmodule

// File: tb/tb_exp_scale_sched.sv
// Directed bench for exp_scale_sched with a registered LUT model and a
// response scoreboard filled at each request handshake.
module tb_exp_scale_sched;

    localparam int NUM_REQ   = 4;
    localparam int IDX_W     = 4;
    localparam int SCALE_W   = 12;
    localparam int LUT_LAT   = 1;
    localparam int OUT_DEPTH = 4;
    localparam int ID_W      = 2;

    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [SCALE_W-1:0] scale;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ*IDX_W-1:0] req_idx = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic [IDX_W-1:0]         lut_idx;
    logic [SCALE_W-1:0]       lut_scale;
    logic                     rsp_valid;
    logic                     rsp_ready = 1'b0;
    logic [ID_W-1:0]          rsp_id;
    logic [SCALE_W-1:0]       rsp_scale;
    logic                     busy;

    int   checks    = 0;
    int   errors    = 0;
    int   rsp_count = 0;
    exp_t sb [$];
    exp_t mon_e;

    logic [3:0] idx4 [4] = '{4'h0, 4'h8, 4'hD, 4'h3};
    logic [3:0] fair_valid [8] = '{4'b0101, 4'b0101, 4'b0101, 4'b0101,
                                   4'b0111, 4'b0111, 4'b0101, 4'b0101};
    logic [3:0] fair_gnt [8]   = '{4'b0001, 4'b0100, 4'b0001, 4'b0100,
                                   4'b0001, 4'b0010, 4'b0100, 4'b0001};

    exp_scale_sched #(
        .NUM_REQ   (NUM_REQ),
        .IDX_W     (IDX_W),
        .SCALE_W   (SCALE_W),
        .LUT_LAT   (LUT_LAT),
        .OUT_DEPTH (OUT_DEPTH),
        .ID_W      (ID_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_idx   (req_idx),
        .req_ready (req_ready),
        .lut_idx   (lut_idx),
        .lut_scale (lut_scale),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_scale (rsp_scale),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] lut_tab(input logic [3:0] i);
        case (i)
            4'h0:    return 12'h100;
            4'h1:    return 12'h2B8;
            4'h3:    return 12'h7FF;
            4'h8:    return 12'h016;
            4'hD:    return 12'hCBF;
            default: return {i, i, i} ^ 12'h5A5;
        endcase
    endfunction

    // Registered LUT model: one cycle from index to scale.
    always @(posedge clk) lut_scale <= lut_tab(lut_idx);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int w = 0; w < 100 && (busy || rsp_valid); w++) tick();
        chk(tag, {30'b0, busy, rsp_valid}, 32'h0);
    endtask

    // Scoreboard: push at request handshake, compare at response handshake.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                rsp_count++;
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 32'(sb.size()), 32'd1);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rsp_data", {18'b0, rsp_id, rsp_scale}, {18'b0, mon_e});
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i])
                    sb.push_back(exp_t'{id: ID_W'(i), scale: lut_tab(req_idx[i*IDX_W +: IDX_W])});
            end
        end
    end

    initial begin
        int  base;
        logic got;
        logic [3:0] idx;

        // Reset state
        do_reset();
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_scale", rsp_scale, 0);
        chk("rst_lut_idx", lut_idx, 0);

        // Single request: idx 1 from requester 0
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        req_idx   = 16'h0001;
        #1;
        chk("single_gnt", req_ready, 32'h1);
        chk("single_lut_idx", lut_idx, 32'h1);
        tick();
        req_valid = '0;
        #1;
        chk("single_t1_valid", rsp_valid, 0);
        chk("single_t1_busy", busy, 1);
        tick();
        #1;
        chk("single_t2_valid", rsp_valid, 1);
        chk("single_t2_id", rsp_id, 0);
        chk("single_t2_scale", rsp_scale, 32'h2B8);
        tick();
        #1;
        chk("single_t3_busy", busy, 0);
        chk("single_t3_valid", rsp_valid, 0);

        // All four valid: strict rotation, back-to-back responses
        do_reset();
        rsp_ready = 1'b1;
        req_idx   = 16'h3D80;
        for (int k = 0; k < 10; k++) begin
            req_valid = (k < 8) ? 4'hF : 4'h0;
            #1;
            if (k < 8) begin
                chk("rr_gnt", req_ready, 32'(1 << (k % 4)));
                chk("rr_lut_idx", lut_idx, 32'(idx4[k % 4]));
            end
            chk("rr_rsp_valid", rsp_valid, 32'(k >= 2));
            tick();
        end
        wait_idle("rr_idle");

        // Backpressure: exactly OUT_DEPTH grants, resume one cycle after pop
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        req_idx   = 16'h0050;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("bp_gnt", req_ready, (k < 4) ? 32'h2 : 32'h0);
            if (k >= 4) begin
                chk("bp_hold_id", rsp_id, 32'h1);
                chk("bp_hold_scale", rsp_scale, 32'(lut_tab(4'h5)));
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_pop_no_credit", req_ready, 32'h0);
        tick();
        #1;
        chk("bp_resume", req_ready, 32'h2);
        tick();
        req_valid = '0;
        wait_idle("bp_idle");

        // FIFO wrap: 20 lookups with random consumer stalls
        base = rsp_count;
        for (int i = 0; i < 20; i++) begin
            got       = 1'b0;
            idx       = 4'((i * 7 + 3) % 16);
            req_valid = 4'b0100;
            req_idx   = {4'h0, idx, 8'h00};
            for (int w = 0; w < 50 && !got; w++) begin
                rsp_ready = 1'($urandom_range(0, 1));
                #1;
                if (req_ready[2]) got = 1'b1;
                tick();
            end
            chk("wrap_grant_wait", got, 1);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle("wrap_idle");
        chk("wrap_count", 32'(rsp_count - base), 32'd20);
        chk("wrap_sb_empty", 32'(sb.size()), 32'd0);

        // Reset mid-operation
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        req_idx   = 16'h0001;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("mid_gnt", req_ready, 32'h1);
            tick();
        end
        req_valid = '0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_req_ready", req_ready, 0);
        chk("mid_rsp_scale", rsp_scale, 0);
        tick();
        #1;
        chk("mid_stale_valid", rsp_valid, 0);
        chk("mid_stale_busy", busy, 0);
        rsp_ready = 1'b1;
        req_valid = 4'b1000;
        req_idx   = 16'hD000;
        #1;
        chk("mid_new_gnt", req_ready, 32'h8);
        chk("mid_new_lut_idx", lut_idx, 32'hD);
        tick();
        req_valid = '0;
        tick();
        #1;
        chk("mid_new_valid", rsp_valid, 1);
        chk("mid_new_id", rsp_id, 32'h3);
        chk("mid_new_scale", rsp_scale, 32'hCBF);
        wait_idle("mid_idle");

        // Fairness: req1 pulsed among continuous req0/req2
        do_reset();
        rsp_ready = 1'b1;
        req_idx   = 16'h0000;
        for (int k = 0; k < 8; k++) begin
            req_valid = fair_valid[k];
            #1;
            chk("fair_gnt", req_ready, 32'(fair_gnt[k]));
            tick();
        end
        req_valid = '0;
        wait_idle("fair_idle");
        chk("fair_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
